// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and arithmetic helpers for the
// 16-bit ALU datapath.
package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [3:0] MAJ_BASIC = 4'b0000;
    localparam logic [3:0] MAJ_ADDI  = 4'b0101;
    localparam logic [3:0] MAJ_ADDUI = 4'b0110;
    localparam logic [3:0] MAJ_ADDCI = 4'b0111;
    localparam logic [3:0] MAJ_SHIFT = 4'b1000;

    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOT   = 4'b0100;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_ADDU  = 4'b0110;
    localparam logic [3:0] OP_ADDC  = 4'b0111;
    localparam logic [3:0] OP_ADDCU = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_CMPU  = 4'b1111;

    localparam logic [3:0] SH_LSHI0 = 4'b0000;
    localparam logic [3:0] SH_LSHI1 = 4'b0001;
    localparam logic [3:0] SH_LSH   = 4'b0100;
    localparam logic [3:0] SH_RSH   = 4'b1000;
    localparam logic [3:0] SH_RSHI  = 4'b1001;
    localparam logic [3:0] SH_ALSH  = 4'b1010;
    localparam logic [3:0] SH_ARSH  = 4'b1011;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    function automatic logic [WIDTH:0] add17(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    function automatic logic ovf_signed(input logic a15, input logic b15, input logic c15);
        return (~a15 & ~b15 & c15) | (a15 & b15 & ~c15);
    endfunction

    function automatic logic ovf_unsigned(input logic a15, input logic b15, input logic c15);
        return (a15 | b15) & ~c15;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: decodes the opcode and produces the next result
// and ZCFNL flags for the output register in alu_core.
module alu_comb
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [7:0]       opcode_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] next_c_o,
    output logic [4:0]       next_flags_o
);

    logic [3:0]       maj_s;
    logic [3:0]       min_s;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic [4:0]       flg_s;
    logic             use_rz_s;
    logic             cmp_z_s;

    assign maj_s = opcode_i[7:4];
    assign min_s = opcode_i[3:0];
    assign imm_s = {8'h00, opcode_i};

    // Opcode decode; Z is resolved after the case from either the result or the compare.
    always_comb begin
        res_s    = 16'h0000;
        flg_s    = 5'b00000;
        sum_s    = 17'h00000;
        use_rz_s = 1'b0;
        cmp_z_s  = 1'b0;
        case (maj_s)
            MAJ_BASIC: begin
                case (min_s)
                    OP_AND:   begin res_s = a_i & b_i; use_rz_s = 1'b1; end
                    OP_OR:    begin res_s = a_i | b_i; use_rz_s = 1'b1; end
                    OP_XOR:   begin res_s = a_i ^ b_i; use_rz_s = 1'b1; end
                    OP_NOT:   begin res_s = ~a_i;      use_rz_s = 1'b1; end
                    OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
                        sum_s = add17(a_i, b_i,
                                      ((min_s == OP_ADDC) || (min_s == OP_ADDCU)) ? cin_i : 1'b0);
                        res_s = sum_s[WIDTH-1:0];
                        use_rz_s = 1'b1;
                        flg_s[FLAG_C] = sum_s[WIDTH];
                        flg_s[FLAG_F] = ((min_s == OP_ADD) || (min_s == OP_ADDC))
                                      ? ovf_signed(a_i[15], b_i[15], res_s[15])
                                      : ovf_unsigned(a_i[15], b_i[15], res_s[15]);
                    end
                    OP_SUB: begin
                        res_s = a_i - b_i;
                        use_rz_s = 1'b1;
                        flg_s[FLAG_F] = (~a_i[15] & b_i[15] & res_s[15]) |
                                        (a_i[15] & ~b_i[15] & ~res_s[15]);
                    end
                    OP_CMP: begin
                        cmp_z_s = (a_i == b_i);
                        flg_s[FLAG_N] = ($signed(a_i) < $signed(b_i));
                        flg_s[FLAG_L] = ($signed(a_i) < $signed(b_i));
                    end
                    OP_CMPU: begin
                        cmp_z_s = (a_i == b_i);
                        flg_s[FLAG_L] = (a_i < b_i);
                    end
                    default: begin
                        res_s = 16'h0000;
                        flg_s = 5'b00000;
                    end
                endcase
            end
            MAJ_ADDI, MAJ_ADDUI, MAJ_ADDCI: begin
                // Immediate has bit15 clear, so the overflow rules reduce accordingly.
                sum_s = add17(a_i, imm_s, (maj_s == MAJ_ADDCI) ? cin_i : 1'b0);
                res_s = sum_s[WIDTH-1:0];
                use_rz_s = 1'b1;
                flg_s[FLAG_C] = sum_s[WIDTH];
                flg_s[FLAG_F] = (maj_s == MAJ_ADDUI)
                              ? ovf_unsigned(a_i[15], 1'b0, res_s[15])
                              : ovf_signed(a_i[15], 1'b0, res_s[15]);
            end
            MAJ_SHIFT: begin
                case (min_s)
                    SH_LSHI0, SH_LSHI1: begin res_s = a_i << b_i[3:0]; use_rz_s = 1'b1; end
                    SH_LSH:  begin res_s = {a_i[14:0], 1'b0};          use_rz_s = 1'b1; end
                    SH_RSH:  begin res_s = {1'b0, a_i[15:1]};          use_rz_s = 1'b1; end
                    SH_RSHI: begin res_s = a_i >> b_i[3:0];            use_rz_s = 1'b1; end
                    SH_ALSH: begin res_s = {a_i[15], a_i[13:0], 1'b0}; use_rz_s = 1'b1; end
                    SH_ARSH: begin res_s = {a_i[15], a_i[15:1]};       use_rz_s = 1'b1; end
                    default: begin
                        res_s = 16'h0000;
                        flg_s = 5'b00000;
                    end
                endcase
            end
            default: begin
                res_s = 16'h0000;
                flg_s = 5'b00000;
            end
        endcase
        flg_s[FLAG_Z] = use_rz_s ? (res_s == 16'h0000) : cmp_z_s;
    end

    assign next_c_o     = res_s;
    assign next_flags_o = flg_s;

endmodule

// File: rtl/alu_core.sv
// Registered 16-bit ALU: the combinational datapath followed by the C/Flags
// output register that the register file and PSR load from.
module alu_core
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [7:0]       Opcode,
    input  logic             Cin,
    output logic [WIDTH-1:0] C,
    output logic [4:0]       Flags
);

    logic [WIDTH-1:0] c_d;
    logic [4:0]       flags_d;
    logic [WIDTH-1:0] c_q;
    logic [4:0]       flags_q;

    alu_comb u_comb (
        .a_i          (A),
        .b_i          (B),
        .opcode_i     (Opcode),
        .cin_i        (Cin),
        .next_c_o     (c_d),
        .next_flags_o (flags_d)
    );

    // Output register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q     <= 16'h0000;
            flags_q <= 5'b00000;
        end else begin
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    assign C     = c_q;
    assign Flags = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: a table of hand-computed results plus
// short sequences for reset and pipeline timing.
module tb_alu_core;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_c;
        logic [4:0]  exp_f;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [7:0]  Opcode;
    logic        Cin;
    logic [15:0] C;
    logic [4:0]  Flags;

    int checks;
    int failures;
    vec_t vecs[$];

    alu_core dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .Opcode (Opcode),
        .Cin    (Cin),
        .C      (C),
        .Flags  (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input string n, input logic [7:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic cin,
                           input logic [15:0] ec, input logic [4:0] ef);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.cin = cin; v.exp_c = ec; v.exp_f = ef;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [15:0] ec, input logic [4:0] ef);
        checks++;
        if (C !== ec || Flags !== ef) begin
            failures++;
            $display("FAIL %s: C=%h Flags=%b expected C=%h Flags=%b", n, C, Flags, ec, ef);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        Opcode = op; A = a; B = b; Cin = cin;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        drive(8'h00, 16'h0000, 16'h0000, 1'b0);

        add_vec("and_zero",   8'h01, 16'h00F0, 16'h0F00, 1'b0, 16'h0000, 5'b10000);
        add_vec("and",        8'h01, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 5'b00000);
        add_vec("or",         8'h02, 16'h1200, 16'h0034, 1'b0, 16'h1234, 5'b00000);
        add_vec("xor_zero",   8'h03, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 5'b10000);
        add_vec("not",        8'h04, 16'h0F0F, 16'h1234, 1'b0, 16'hF0F0, 5'b00000);
        add_vec("add_ovf",    8'h05, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b00100);
        add_vec("add_wrap",   8'h05, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b11000);
        add_vec("add_cinign", 8'h05, 16'h0002, 16'h0003, 1'b1, 16'h0005, 5'b00000);
        add_vec("addu",       8'h06, 16'h8000, 16'h0001, 1'b0, 16'h8001, 5'b00000);
        add_vec("addu_ovf",   8'h06, 16'h8000, 16'h8000, 1'b0, 16'h0000, 5'b11100);
        add_vec("addc",       8'h07, 16'h0005, 16'h0006, 1'b1, 16'h000C, 5'b00000);
        add_vec("addc_wrap",  8'h07, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 5'b11000);
        add_vec("addcu",      8'h08, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 5'b00000);
        add_vec("addcu_ovf",  8'h08, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b11100);
        add_vec("sub_neg",    8'h09, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 5'b00000);
        add_vec("sub_ovf",    8'h09, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b00100);
        add_vec("sub_zero",   8'h09, 16'h0005, 16'h0005, 1'b0, 16'h0000, 5'b10000);
        add_vec("cmp_lt",     8'h0B, 16'hFFFE, 16'h0001, 1'b0, 16'h0000, 5'b00011);
        add_vec("cmpu_gt",    8'h0F, 16'hFFFE, 16'h0001, 1'b0, 16'h0000, 5'b00000);
        add_vec("cmp_eq",     8'h0B, 16'h0007, 16'h0007, 1'b0, 16'h0000, 5'b10000);
        add_vec("cmpu_lt",    8'h0F, 16'h0001, 16'hFFFE, 1'b0, 16'h0000, 5'b00001);
        add_vec("cmp_gt",     8'h0B, 16'h0001, 16'hFFFE, 1'b0, 16'h0000, 5'b00000);
        add_vec("addi",       8'h5A, 16'h0010, 16'hFFFF, 1'b1, 16'h006A, 5'b00000);
        add_vec("addi_ovf",   8'h50, 16'h7FFF, 16'h0000, 1'b0, 16'h804F, 5'b00100);
        add_vec("addi_carry", 8'h5F, 16'hFFFF, 16'h0000, 1'b0, 16'h005E, 5'b01000);
        add_vec("addui",      8'h61, 16'h8000, 16'h0000, 1'b0, 16'h8061, 5'b00000);
        add_vec("addui_ovf",  8'h6F, 16'hFFF0, 16'h0000, 1'b0, 16'h005F, 5'b01100);
        add_vec("addci_c1",   8'h70, 16'h0001, 16'h0000, 1'b1, 16'h0072, 5'b00000);
        add_vec("addci_c0",   8'h70, 16'h0001, 16'h0000, 1'b0, 16'h0071, 5'b00000);
        add_vec("lshi4",      8'h80, 16'h1234, 16'h0004, 1'b0, 16'h2340, 5'b00000);
        add_vec("lshi0",      8'h81, 16'h1234, 16'h0000, 1'b1, 16'h1234, 5'b00000);
        add_vec("lshi15",     8'h80, 16'hFFFF, 16'h000F, 1'b0, 16'h8000, 5'b00000);
        add_vec("rshi4",      8'h89, 16'h1234, 16'h0004, 1'b0, 16'h0123, 5'b00000);
        add_vec("rshi15",     8'h89, 16'hFFFF, 16'h000F, 1'b0, 16'h0001, 5'b00000);
        add_vec("rshi_b16",   8'h89, 16'h1234, 16'h0010, 1'b0, 16'h1234, 5'b00000);
        add_vec("lsh_zero",   8'h84, 16'h8000, 16'h0000, 1'b0, 16'h0000, 5'b10000);
        add_vec("rsh",        8'h88, 16'h8001, 16'h0000, 1'b0, 16'h4000, 5'b00000);
        add_vec("alsh",       8'h8A, 16'hC001, 16'h0000, 1'b0, 16'h8002, 5'b00000);
        add_vec("alsh_zero",  8'h8A, 16'h4000, 16'h0000, 1'b0, 16'h0000, 5'b10000);
        add_vec("arsh",       8'h8B, 16'h8004, 16'h0000, 1'b0, 16'hC002, 5'b00000);
        add_vec("undef_20",   8'h20, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 5'b00000);
        add_vec("undef_00",   8'h00, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 5'b00000);
        add_vec("undef_0a",   8'h0A, 16'h0001, 16'h0002, 1'b0, 16'h0000, 5'b00000);
        add_vec("undef_85",   8'h85, 16'h1234, 16'h0001, 1'b0, 16'h0000, 5'b00000);
        add_vec("undef_9f",   8'h9F, 16'h1234, 16'h0001, 1'b0, 16'h0000, 5'b00000);
        add_vec("undef_f3",   8'hF3, 16'h1234, 16'h0001, 1'b0, 16'h0000, 5'b00000);

        // Reset state
        repeat (2) @(posedge clk);
        #1 check("reset_state", 16'h0000, 5'b00000);
        reset = 1'b0;

        // Load a nonzero result, then assert reset mid-cycle with an ADD pending.
        drive(8'h02, 16'h00A5, 16'h5A00, 1'b0);
        @(posedge clk); #1 check("pre_reset", 16'h5AA5, 5'b00000);
        drive(8'h05, 16'h1000, 16'h0001, 1'b0);
        #2 reset = 1'b1;
        #1 check("async_reset", 16'h0000, 5'b00000);
        @(posedge clk); #1 check("reset_hold", 16'h0000, 5'b00000);
        #2 reset = 1'b0;
        drive(8'h01, 16'h00F0, 16'h0F00, 1'b0);
        @(posedge clk); #1 check("post_reset_and", 16'h0000, 5'b10000);
        drive(8'h05, 16'h1000, 16'h0001, 1'b0);
        @(posedge clk); #1 check("post_reset_add", 16'h1001, 5'b00000);

        // Back-to-back: output holds until the edge, then shows the prior op.
        drive(8'h09, 16'h0009, 16'h0004, 1'b0);
        #3 check("hold_before_edge", 16'h1001, 5'b00000);
        @(posedge clk); #1 check("b2b_sub", 16'h0005, 5'b00000);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].exp_c, vecs[i].exp_f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 16-bit registered ALU for the datapath of the 16-bit CPU.
- Decodes an 8-bit opcode: logic, add/sub, compare, shift and add-immediate operations on operands A and B, with a carry-in.
- Produces a 16-bit result C and a 5-bit ZCFNL flag vector.
- Both outputs are registered: one cycle of latency. The register file and PSR load from them.

Parameters:
- WIDTH, 16, operand/result width. Fixed. The flag rules assume 16.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears C and Flags
- A  in  16  operand A (destination register value)
- B  in  16  operand B (source register value)
- Opcode  in  8  [7:4] major op, [3:0] minor op or immediate
- Cin  in  1  carry-in for ADDC/ADDCU/ADDCI
- C  out  16  registered result
- Flags  out  5  registered {Z,C,F,N,L}: [4] zero, [3] carry, [2] overflow, [1] negative, [0] low

Behaviour:
- Timing:
  - Combinational compute from A, B, Opcode, Cin.
  - Registered into C/Flags on each rising clk.
  - Latency 1 cycle, no stall, no handshake.
  - reset=1 forces C=0 and Flags=0 immediately, at any time, including mid-stream. The first edge after release loads a valid result.
- Logic ops (Opcode=0000_xxxx). Z=(result==0); Flags[3:0]=0.
  - 0001 AND: A&B
  - 0010 OR: A|B
  - 0011 XOR: A^B
  - 0100 NOT: ~A
- Add ops (0000_xxxx). {Cflag,C} = 17-bit sum. Z=(C==0). N=L=0.
  - 0101 ADD: A+B; F = signed overflow, (~A15&~B15&C15)|(A15&B15&~C15)
  - 0110 ADDU: A+B; F=(A15|B15)&~C15
  - 0111 ADDC: A+B+Cin; F as ADD
  - 1000 ADDCU: A+B+Cin; F as ADDU
- 0000_1001 SUB:
  - C=A-B (mod 2^16).
  - F=(~A15&B15&C15)|(A15&~B15&~C15).
  - Z=(C==0); carry=N=L=0.
- 0000_1011 CMP:
  - C=0.
  - Z=(A==B).
  - N=L=($signed(A)<$signed(B)).
  - carry=F=0.
- 0000_1111 CMPU:
  - C=0.
  - Z=(A==B).
  - L=(A<B, unsigned).
  - carry=F=N=0.
- Add immediate. Immediate = zero-extended full Opcode[7:0]. Flag rules are the same as the register form, with the immediate as second operand (its bit15=0).
  - 0101_xxxx ADDI: A+imm
  - 0110_xxxx ADDUI: A+imm
  - 0111_xxxx ADDCI: A+imm+Cin
- Shifts (1000_xxxx). Z=(C==0); Flags[3:0]=0.
  - 0000, 0001 LSHI: A<<B[3:0]
  - 0100 LSH: A<<1
  - 1000 RSH: A>>1, logical
  - 1001 RSHI: A>>B[3:0], logical
  - 1010 ALSH: (A<<1) with bit15 forced to A[15]
  - 1011 ARSH: arithmetic A>>>1, bit15=A[15]
- Any other opcode (unused minors, majors 0001-0100, 1001-1111): C=0, Flags=0.
- Boundaries:
  - 0xFFFF+1 → C=0, Z=1, carry=1.
  - Shift by 0 passes A through.
  - Shifts of 15 keep only 1 bit.
  - Cin is ignored by all non-carry ops.

Decomposition:
- Shared package alu_pkg holds:
  - major/minor opcode constants (OP_AND…OP_CMPU, MAJ_BASIC=0000, MAJ_ADDI=0101, MAJ_ADDUI=0110, MAJ_ADDCI=0111, MAJ_SHIFT=1000, SH_LSHI…SH_ARSH);
  - flag bit indices FLAG_Z=4, FLAG_C=3, FLAG_F=2, FLAG_N=1, FLAG_L=0.
- One natural sub-module: alu_comb, the purely combinational datapath producing next_C/next_Flags. alu_core wraps it with the output register.

Test Plan:
- reset=1 mid-stream with ADD pending → C=0, Flags=0 immediately; after release, next edge with AND, A=0x00F0, B=0x0F00 → C=0, Flags=10000.
- ADD, A=0x7FFF, B=0x0001 → C=0x8000, Flags=00100. ADD, A=0xFFFF, B=0x0001 → C=0, Flags=11000.
- ADDC, A=5, B=6, Cin=1 → C=12, Flags=00000. ADDI, Opcode=0x5A, A=0x0010 → C=0x006A.
- SUB, A=3, B=5 → C=0xFFFE, Flags=00000. CMP, A=0xFFFE(-2), B=1 → C=0, Flags=00011. CMPU, same operands → Flags=00000. CMP, A=B=7 → Flags=10000.
- Shifts:
  - ARSH, A=0x8004 → C=0xC002.
  - ALSH, A=0xC001 → C=0x8002.
  - RSHI, B=4, A=0x1234 → C=0x0123.
  - LSH, A=0x8000 → C=0, Flags=10000.
- Undefined Opcode 0x20, A=B=0xFFFF → C=0, Flags=00000. Back-to-back ops each appear exactly one cycle later.
